// File: rtl/chip8_scanout.sv
// chip8_scanout: streams the 64x32 CHIP-8 framebuffer as a scaled 1-bit pixel stream aligned to
// external hcount/vcount. Optional sticky underrun flag: define CHIP8_SCANOUT_UNDERRUN_EN.
module chip8_scanout #(
  parameter logic [11:0] FB_BASE  = 12'hF00,
  parameter int          SCALE    = 20,
  parameter int          H_OFF    = 0,
  parameter int          V_OFF    = 40,
  parameter int          HCOUNT_W = 11,
  parameter int          VCOUNT_W = 10,
  parameter logic [1:0]  MEM_TYPE = 2'd1
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic [7:0]          mem_data_in,
  input  logic                mem_ready_in,
  input  logic                mem_valid_in,
  output logic [11:0]         mem_addr_out,
  output logic                mem_valid_out,
  output logic                mem_we_out,
  output logic [1:0]          mem_type_out,
  output logic                pixel_out,
  output logic                active_out
`ifdef CHIP8_SCANOUT_UNDERRUN_EN
  ,
  output logic                underrun_out,
  input  logic                underrun_clr_in
`endif
);

  localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int H_END = H_OFF + 64 * SCALE;
  localparam int V_END = V_OFF + 32 * SCALE;
  localparam logic [SW-1:0] SUB_MAX = SW'(SCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  // Sub-counters follow the raster: forced to 0 at the window origin, stepped whenever the count moves.
  logic [HCOUNT_W-1:0] h_prev;
  logic [VCOUNT_W-1:0] v_prev;
  logic [SW-1:0]       h_sub_q, h_sub, v_sub_q, v_sub;
  logic [5:0]          h_x_q, h_x;
  logic [4:0]          v_y_q, v_y;

  always_comb begin
    h_sub = h_sub_q;
    h_x   = h_x_q;
    if (int'(hcount_in) == H_OFF) begin
      h_sub = '0;
      h_x   = '0;
    end else if (hcount_in != h_prev) begin
      if (h_sub_q == SUB_MAX) begin
        h_sub = '0;
        h_x   = h_x_q + 6'd1;
      end else begin
        h_sub = h_sub_q + SW'(1);
      end
    end
  end

  always_comb begin
    v_sub = v_sub_q;
    v_y   = v_y_q;
    if (int'(vcount_in) == V_OFF) begin
      v_sub = '0;
      v_y   = '0;
    end else if (vcount_in != v_prev) begin
      if (v_sub_q == SUB_MAX) begin
        v_sub = '0;
        v_y   = v_y_q + 5'd1;
      end else begin
        v_sub = v_sub_q + SW'(1);
      end
    end
  end

  logic h_in, v_in, in_win, line_start;
  logic swap, trig_first, trig_next, trigger;
  logic [4:0] trig_row;

  assign h_in       = (int'(hcount_in) >= H_OFF) && (int'(hcount_in) < H_END);
  assign v_in       = (int'(vcount_in) >= V_OFF) && (int'(vcount_in) < V_END);
  assign in_win     = h_in && v_in;
  assign line_start = (hcount_in == '0);
  assign swap       = line_start && v_in && (v_sub == '0);
  assign trig_first = line_start && (int'(vcount_in) == V_OFF - 1);
  assign trig_next  = swap && (v_y != 5'd31);
  assign trigger    = trig_first || trig_next;
  assign trig_row   = trig_first ? 5'd0 : v_y + 5'd1;

  state_t        state_q, state_d;
  logic [4:0]    row_q, row_d, pend_row_q, pend_row_d;
  logic [2:0]    byte_q, byte_d;
  logic          pend_q, pend_d, wr_en;
  logic [11:0]   addr_q;
  logic [7:0][7:0] shadow_q, active_q;
  logic          pixel_q, active_win_q;

  // A trigger that lands mid-fetch is parked; the outstanding response is still taken before restarting.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    byte_d     = byte_q;
    pend_d     = pend_q;
    pend_row_d = pend_row_q;
    wr_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          row_d   = trig_row;
          byte_d  = '0;
          pend_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (trigger) begin
          pend_d     = 1'b1;
          pend_row_d = trig_row;
        end
        if (mem_ready_in) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (trigger) begin
          pend_d     = 1'b1;
          pend_row_d = trig_row;
        end
        if (mem_valid_in) begin
          wr_en = 1'b1;
          if (trigger || pend_q) begin
            row_d   = trigger ? trig_row : pend_row_q;
            byte_d  = '0;
            pend_d  = 1'b0;
            state_d = S_REQ;
          end else if (byte_q == 3'd7) begin
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_q + 3'd1;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      h_prev       <= '0;
      v_prev       <= '0;
      h_sub_q      <= '0;
      v_sub_q      <= '0;
      h_x_q        <= '0;
      v_y_q        <= '0;
      state_q      <= S_IDLE;
      row_q        <= '0;
      byte_q       <= '0;
      pend_q       <= 1'b0;
      pend_row_q   <= '0;
      addr_q       <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pixel_q      <= 1'b0;
      active_win_q <= 1'b0;
    end else begin
      h_prev     <= hcount_in;
      v_prev     <= vcount_in;
      h_sub_q    <= h_sub;
      v_sub_q    <= v_sub;
      h_x_q      <= h_x;
      v_y_q      <= v_y;
      state_q    <= state_d;
      row_q      <= row_d;
      byte_q     <= byte_d;
      pend_q     <= pend_d;
      pend_row_q <= pend_row_d;
      if (state_d == S_REQ && state_q != S_REQ)
        addr_q <= FB_BASE + {4'b0, row_d, 3'b000} + {9'b0, byte_d};
      if (wr_en) shadow_q[byte_q] <= mem_data_in;
      // Swap reads the shadow before this cycle's response write lands.
      if (swap) active_q <= shadow_q;
      pixel_q      <= in_win && active_q[h_x[5:3]][~h_x[2:0]];
      active_win_q <= in_win;
    end
  end

  assign mem_addr_out  = addr_q;
  assign mem_valid_out = (state_q == S_REQ);
  assign mem_we_out    = 1'b0;
  assign mem_type_out  = MEM_TYPE;
  assign pixel_out     = pixel_q;
  assign active_out    = active_win_q;

`ifdef CHIP8_SCANOUT_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                      underrun_q <= 1'b0;
    else if (swap && state_q != S_IDLE) underrun_q <= 1'b1;
    else if (underrun_clr_in)           underrun_q <= 1'b0;
  end

  assign underrun_out = underrun_q;
`endif

endmodule

// File: tb/tb_chip8_scanout.sv
// Directed bench for chip8_scanout: small raster (SCALE=2) with a wrapping framebuffer base.
module tb_chip8_scanout;
  localparam logic [11:0] FB_BASE = 12'hFF8;
  localparam int SCALE = 2, H_OFF = 2, V_OFF = 4;
  localparam int HTOT = 136, VTOT = 72;

  logic        clk_in = 1'b0, rst_n_in = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic [7:0]  mem_data_in = '0;
  logic        mem_ready_in = 1'b0, mem_valid_in = 1'b0;
  logic [11:0] mem_addr_out;
  logic        mem_valid_out, mem_we_out, pixel_out, active_out;
  logic [1:0]  mem_type_out;
`ifdef CHIP8_SCANOUT_UNDERRUN_EN
  logic        underrun_out;
  logic        underrun_clr_in = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  chip8_scanout #(
    .FB_BASE(FB_BASE), .SCALE(SCALE), .H_OFF(H_OFF), .V_OFF(V_OFF),
    .HCOUNT_W(11), .VCOUNT_W(10), .MEM_TYPE(2'd1)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .mem_data_in(mem_data_in), .mem_ready_in(mem_ready_in), .mem_valid_in(mem_valid_in),
    .mem_addr_out(mem_addr_out), .mem_valid_out(mem_valid_out), .mem_we_out(mem_we_out),
    .mem_type_out(mem_type_out), .pixel_out(pixel_out), .active_out(active_out)
`ifdef CHIP8_SCANOUT_UNDERRUN_EN
    , .underrun_out(underrun_out), .underrun_clr_in(underrun_clr_in)
`endif
  );

  logic [7:0]  fb [0:4095];
  logic [11:0] req_log [0:15];
  logic [11:0] paddr, hs_addr, st_addr;
  int  checks = 0, failures = 0;
  int  resp_lat = 0, ready_delay = 0, lat = 0, stall_cnt = 0;
  bit  pend = 0, hs_armed = 0, stalled = 0, run = 0;
  int  nlog, stall_cycles, stab_viol, ph, pv;
  int  pix_bad, act_bad, ones, bad_h, bad_v, first_h, first_v, last_h, last_v;

  function automatic logic exp_pix(int h, int v);
    int x, y;
    logic [11:0] a;
    logic [7:0]  bt;
    if (h < H_OFF || h >= H_OFF + 64*SCALE || v < V_OFF || v >= V_OFF + 32*SCALE) return 1'b0;
    x  = (h - H_OFF) / SCALE;
    y  = (v - V_OFF) / SCALE;
    a  = 12'((int'(FB_BASE) + 8*y + x/8) % 4096);
    bt = fb[a];
    return bt[7 - x%8];
  endfunction

  // One clock: note the (h,v) the DUT just registered, run the memory model, advance the raster.
  task automatic cyc();
    @(negedge clk_in);
    ph = int'(hcount_in);
    pv = int'(vcount_in);
    if (hs_armed) begin
      pend = 1; lat = resp_lat; paddr = hs_addr;
      if (nlog < 16) req_log[nlog] = hs_addr;
      nlog++;
    end
    if (stalled && (mem_valid_out !== 1'b1 || mem_addr_out !== st_addr)) stab_viol++;
    mem_valid_in = 1'b0;
    if (pend) begin
      if (lat == 0) begin mem_valid_in = 1'b1; mem_data_in = fb[paddr]; pend = 0; end
      else lat--;
    end
    hs_armed = 0; stalled = 0; mem_ready_in = 1'b0;
    if (mem_valid_out) begin
      if (stall_cnt >= ready_delay) begin
        mem_ready_in = 1'b1; hs_armed = 1; hs_addr = mem_addr_out; stall_cnt = 0;
      end else begin
        stall_cnt++; stalled = 1; st_addr = mem_addr_out; stall_cycles++;
      end
    end
    if (run) begin
      if (ph == HTOT-1) begin
        hcount_in = '0;
        vcount_in = (pv == VTOT-1) ? '0 : 10'(pv + 1);
      end else begin
        hcount_in = 11'(ph + 1);
      end
    end
  endtask

  task automatic do_reset();
    run = 0; rst_n_in = 1'b0; pend = 0; hs_armed = 0; stalled = 0; stall_cnt = 0;
    mem_valid_in = 1'b0; mem_ready_in = 1'b0; hcount_in = '0; vcount_in = '0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1; run = 1;
  endtask

  task automatic run_frame();
    logic ea, ep;
    pix_bad = 0; act_bad = 0; ones = 0; nlog = 0; stall_cycles = 0; stab_viol = 0;
    bad_h = -1; bad_v = -1; first_h = -1; first_v = -1; last_h = -1; last_v = -1;
    for (int i = 0; i < HTOT*VTOT; i++) begin
      cyc();
      ea = (ph >= H_OFF && ph < H_OFF + 64*SCALE && pv >= V_OFF && pv < V_OFF + 32*SCALE);
      ep = exp_pix(ph, pv);
      if (active_out !== ea) act_bad++;
      if (pixel_out !== ep) begin
        if (pix_bad == 0) begin bad_h = ph; bad_v = pv; end
        pix_bad++;
      end
      if (pixel_out === 1'b1) begin
        if (ones == 0) begin first_h = ph; first_v = pv; end
        last_h = ph; last_v = pv; ones++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++; if (pixel_out !== 1'b0) begin failures++; $display("FAIL reset_pixel got=%b exp=0", pixel_out); end
    checks++; if (active_out !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active_out); end
    checks++; if (mem_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", mem_valid_out); end
    checks++; if (mem_addr_out !== 12'h000) begin failures++; $display("FAIL reset_addr got=%h exp=000", mem_addr_out); end
    checks++; if (mem_we_out !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we_out); end
    checks++; if (mem_type_out !== 2'd1) begin failures++; $display("FAIL reset_type got=%0d exp=1", mem_type_out); end
    do_reset();
  endtask

  task automatic test_single_pixel();
    for (int a = 0; a < 4096; a++) fb[a] = 8'h00;
    fb[12'hFF8] = 8'h80;
    run_frame();
    checks++; if (pix_bad !== 0) begin failures++; $display("FAIL single_pix bad=%0d first at h=%0d v=%0d exp=0", pix_bad, bad_h, bad_v); end
    checks++; if (act_bad !== 0) begin failures++; $display("FAIL single_active bad=%0d exp=0", act_bad); end
    checks++; if (ones !== 4) begin failures++; $display("FAIL single_ones got=%0d exp=4", ones); end
    checks++; if (first_h !== 2 || first_v !== 4) begin failures++; $display("FAIL single_first got=(%0d,%0d) exp=(2,4)", first_h, first_v); end
    checks++; if (last_h !== 3 || last_v !== 5) begin failures++; $display("FAIL single_last got=(%0d,%0d) exp=(3,5)", last_h, last_v); end
    checks++; if (nlog !== 256) begin failures++; $display("FAIL single_nreq got=%0d exp=256", nlog); end
    checks++; if (req_log[0] !== 12'hFF8) begin failures++; $display("FAIL row0_addr got=%h exp=ff8", req_log[0]); end
    checks++; if (req_log[7] !== 12'hFFF) begin failures++; $display("FAIL row0_last_addr got=%h exp=fff", req_log[7]); end
    checks++; if (req_log[8] !== 12'h000) begin failures++; $display("FAIL row1_wrap_addr got=%h exp=000", req_log[8]); end
    checks++; if (req_log[15] !== 12'h007) begin failures++; $display("FAIL row1_last_addr got=%h exp=007", req_log[15]); end
  endtask

  task automatic test_row31();
    for (int a = 0; a < 4096; a++) fb[a] = 8'h00;
    fb[12'h0F7] = 8'h01;
    run_frame();
    checks++; if (pix_bad !== 0) begin failures++; $display("FAIL row31_pix bad=%0d first at h=%0d v=%0d exp=0", pix_bad, bad_h, bad_v); end
    checks++; if (ones !== 4) begin failures++; $display("FAIL row31_ones got=%0d exp=4", ones); end
    checks++; if (first_h !== 128 || first_v !== 66) begin failures++; $display("FAIL row31_first got=(%0d,%0d) exp=(128,66)", first_h, first_v); end
    checks++; if (last_h !== 129 || last_v !== 67) begin failures++; $display("FAIL row31_last got=(%0d,%0d) exp=(129,67)", last_h, last_v); end
  endtask

  task automatic test_pattern();
    for (int a = 0; a < 4096; a++) fb[a] = 8'(a) ^ 8'h5A;
    run_frame();
    checks++; if (pix_bad !== 0) begin failures++; $display("FAIL pattern_pix bad=%0d first at h=%0d v=%0d exp=0", pix_bad, bad_h, bad_v); end
    checks++; if (act_bad !== 0) begin failures++; $display("FAIL pattern_active bad=%0d exp=0", act_bad); end
  endtask

  task automatic test_ready_stall();
    for (int a = 0; a < 4096; a++) fb[a] = 8'($urandom);
    ready_delay = 5;
    run_frame();
    ready_delay = 0;
    checks++; if (pix_bad !== 0) begin failures++; $display("FAIL stall_pix bad=%0d first at h=%0d v=%0d exp=0", pix_bad, bad_h, bad_v); end
    checks++; if (stab_viol !== 0) begin failures++; $display("FAIL stall_hold violations=%0d exp=0", stab_viol); end
    checks++; if (stall_cycles !== 1280) begin failures++; $display("FAIL stall_cycles got=%0d exp=1280", stall_cycles); end
    checks++; if (nlog !== 256) begin failures++; $display("FAIL stall_nreq got=%0d exp=256", nlog); end
    checks++; if (req_log[8] !== 12'h000) begin failures++; $display("FAIL stall_row1_addr got=%h exp=000", req_log[8]); end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    for (int a = 0; a < 4096; a++) fb[a] = 8'hFF;
    resp_lat = 10;
    for (int i = 0; i < 2*HTOT*VTOT && !found; i++) begin
      cyc();
      if (pv == V_OFF + 2 && ph == 6) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL async_timeout got=not_reached exp=h6_v6"); end
    checks++; if (pixel_out !== 1'b1) begin failures++; $display("FAIL async_pre_pixel got=%b exp=1", pixel_out); end
    checks++; if (mem_valid_out !== 1'b0) begin failures++; $display("FAIL async_pre_valid got=%b exp=0", mem_valid_out); end
    #1 rst_n_in = 1'b0;
    #1;
    checks++; if (pixel_out !== 1'b0) begin failures++; $display("FAIL async_pixel got=%b exp=0", pixel_out); end
    checks++; if (active_out !== 1'b0) begin failures++; $display("FAIL async_active got=%b exp=0", active_out); end
    checks++; if (mem_valid_out !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", mem_valid_out); end
    checks++; if (mem_addr_out !== 12'h000) begin failures++; $display("FAIL async_addr got=%h exp=000", mem_addr_out); end
    resp_lat = 0;
    do_reset();
  endtask

`ifdef CHIP8_SCANOUT_UNDERRUN_EN
  task automatic test_underrun();
    bit found = 0;
    resp_lat = 200;
    checks++; if (underrun_out !== 1'b0) begin failures++; $display("FAIL underrun_init got=%b exp=0", underrun_out); end
    for (int i = 0; i < 2*HTOT*VTOT && !found; i++) begin
      cyc();
      if (pv == V_OFF && ph == 5) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL underrun_timeout got=not_reached exp=h5_v4"); end
    checks++; if (underrun_out !== 1'b1) begin failures++; $display("FAIL underrun_set got=%b exp=1", underrun_out); end
    underrun_clr_in = 1'b1;
    cyc();
    underrun_clr_in = 1'b0;
    checks++; if (underrun_out !== 1'b0) begin failures++; $display("FAIL underrun_clr got=%b exp=0", underrun_out); end
    resp_lat = 0;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single_pixel();
    test_row31();
    test_pattern();
    test_ready_stall();
    test_async_reset();
`ifdef CHIP8_SCANOUT_UNDERRUN_EN
    test_underrun();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chip8_scanout.md
Name: chip8_scanout

Overview:
Downstream consumer of the framebuffer that chip8_video writes into chip8_memory. It reads the 64x32 1-bit framebuffer (256 bytes, MSB = leftmost pixel) through a memory read port. Two 64-bit line buffers hold the row being shown and the next row, fetched ahead. It produces a scaled 1-bit pixel stream aligned to external video-timing counters (hcount/vcount) for the HDMI/VGA output stage.

Parameters:
FB_BASE, 12'hF00, byte address of framebuffer row 0, byte 0; row r byte b lives at FB_BASE + 8*r + b.
SCALE, 20, display pixels per CHIP-8 pixel, both axes.
H_OFF, 0, hcount of first active CHIP-8 column.
V_OFF, 40, vcount of first active CHIP-8 row; must be >= 1.
HCOUNT_W, 11, width of hcount_in.
VCOUNT_W, 10, width of vcount_in.
MEM_TYPE, 2'd1, value driven on mem_type_out for read requests.

Ports:
clk_in  input  1  system clock.
rst_n_in  input  1  asynchronous, active-low reset.
hcount_in  input  HCOUNT_W  horizontal pixel count from the timing generator.
vcount_in  input  VCOUNT_W  vertical line count from the timing generator.
mem_data_in  input  8  read response data.
mem_ready_in  input  1  memory accepts the request this cycle.
mem_valid_in  input  1  mem_data_in valid this cycle.
mem_addr_out  output  12  read address.
mem_valid_out  output  1  read request valid.
mem_we_out  output  1  tied 0.
mem_type_out  output  2  constant MEM_TYPE.
pixel_out  output  1  CHIP-8 pixel for the current (hcount,vcount).
active_out  output  1  (hcount,vcount) is inside the 64*SCALE x 32*SCALE window.

Behaviour:
- Reset (async assert, sync release): pixel_out=0, active_out=0, mem_valid_out=0, mem_addr_out=0. Both line buffers are 0. FSM is IDLE. Display row index is 0.
- Window: hcount in [H_OFF, H_OFF+64*SCALE), vcount in [V_OFF, V_OFF+32*SCALE).
- Output latency is 1 cycle: pixel_out and active_out are registered from the current hcount/vcount. Outside the window, pixel_out=0.
- Inside the window: pixel x = (hcount-H_OFF)/SCALE, y = (vcount-V_OFF)/SCALE. pixel_out = bit (7 - x%8) of byte x/8 of the active line buffer.
- Division is done by internal sub-counters that track hcount/vcount. The block does not use a divider.
- Fetch triggers (at hcount==0):
  - vcount==V_OFF-1: fetch row 0.
  - vcount==V_OFF+r*SCALE, r=0..30: fetch row r+1.
  - Row 31 triggers no fetch.
- Swap: at hcount==0 of vcount==V_OFF+r*SCALE, r=0..31, the shadow buffer becomes active. The swap happens before the new trigger fires in the same cycle.
- FSM:
  - IDLE: a trigger loads row and byte=0, then goes to REQ.
  - REQ: mem_valid_out=1, mem_addr_out=FB_BASE+8*row+byte. Both are held stable until mem_ready_in. On mem_ready_in, go to WAIT.
  - WAIT: mem_valid_out=0. On mem_valid_in, write mem_data_in into shadow byte [byte]. If byte==7, go to IDLE; otherwise byte+1 and go to REQ.
  - Only one request is ever outstanding.
  - A response arriving in the same cycle as the request handshake belongs to an earlier request and cannot occur; it is ignored.
- Address arithmetic is 12-bit and wraps modulo 4096.
- Trigger while not IDLE: the in-flight fetch is abandoned at the next IDLE/REQ boundary and the new row restarts at byte 0. A pending mem_valid_in in WAIT is still consumed first.
- Swap while a fetch is incomplete: the swap proceeds and displays whatever bytes the shadow holds.
- rst_n_in asserted mid-fetch aborts immediately. The memory is expected to be reset by the same signal.

Optional Feature:
CHIP8_SCANOUT_UNDERRUN_EN.
- Defined: adds ports underrun_out (output 1) and underrun_clr_in (input 1).
  - underrun_out is a sticky flag, set when a swap occurs while the FSM is not IDLE.
  - It clears on underrun_clr_in or reset.
  - If set and clear occur in the same cycle, set wins.
- Undefined: no extra ports and no flag logic. Underrun behaviour is otherwise identical.

Test Plan:
- Reset with FB bytes 0xF00=0x80, others 0; run one frame -> at (hcount=0..19, vcount=40..59) pixel_out=1 one cycle later; all other window pixels 0; outside window active_out=0.
- Memory with mem_ready_in held low for 5 cycles per request -> mem_valid_out and mem_addr_out stay stable (0xF08 for row 1) until the handshake; row 1 is displayed correctly.
- FB row 31 byte 7 = 0x01 -> pixel_out=1 only at hcount=1260..1279, vcount=660..679.
- FB_BASE=12'hFF8 -> row 1 requests wrap to addresses 0x000..0x007.
- Response latency 200 cycles (fetch exceeds one line-time budget for SCALE=1 configuration), with CHIP8_SCANOUT_UNDERRUN_EN -> underrun_out=1 after the first late swap; pulse underrun_clr_in -> 0.
- Assert rst_n_in low mid-fetch (state WAIT) -> mem_valid_out=0 and pixel_out=0 immediately, without a clock edge.
